// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter that shares one DMA engine among NCH descriptor channels.
// Latches the winning descriptor, starts the DMA, waits for done or timeout, then reports status.
module dma_channel_arbiter #(
  parameter int NCH        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NCH-1:0]            req_i,
  input  logic [NCH*DATA_WIDTH-1:0] len_i,
  input  logic [NCH*DATA_WIDTH-1:0] src_lsb_i,
  input  logic [NCH*DATA_WIDTH-1:0] src_msb_i,
  input  logic [NCH*DATA_WIDTH-1:0] dst_lsb_i,
  input  logic [NCH*DATA_WIDTH-1:0] dst_msb_i,
  output logic [NCH-1:0]            gnt_o,
  output logic [NCH-1:0]            cmp_valid_o,
  output logic [2:0]                cmp_status_o,
  output logic                      busy_o,
  output logic [DATA_WIDTH-1:0]     dma_start_o,
  output logic [DATA_WIDTH-1:0]     dma_len_o,
  output logic [DATA_WIDTH-1:0]     dma_src_lsb_o,
  output logic [DATA_WIDTH-1:0]     dma_src_msb_o,
  output logic [DATA_WIDTH-1:0]     dma_dst_lsb_o,
  output logic [DATA_WIDTH-1:0]     dma_dst_msb_o,
  output logic [DATA_WIDTH-1:0]     dma_done_o,
  input  logic [DATA_WIDTH-1:0]     dma_valid_i
);

  localparam int IW = $clog2(NCH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] rr_q, idx_q, win_idx, cand;
  logic          win_found;
  logic [CW-1:0] cnt_q;
  logic          to_q, ld_ok_q, st_ok_q;
  logic          unused_valid;

  assign unused_valid = ^{dma_valid_i[DATA_WIDTH-1:4], dma_valid_i[0]};

  // Search starts just after the last winner so every channel gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = IW'((int'(rr_q) + i) % NCH);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req_i) state_d = S_ARB;
      S_ARB:    state_d = win_found ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (dma_valid_i[3] || cnt_q == CNT_LAST) state_d = S_ACK;
      S_ACK:    if (!dma_valid_i[3]) state_d = S_REPORT;
      S_REPORT: state_d = (|req_i) ? S_ARB : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      rr_q          <= IW'(NCH - 1);
      idx_q         <= '0;
      cnt_q         <= '0;
      to_q          <= 1'b0;
      ld_ok_q       <= 1'b0;
      st_ok_q       <= 1'b0;
      dma_len_o     <= '0;
      dma_src_lsb_o <= '0;
      dma_src_msb_o <= '0;
      dma_dst_lsb_o <= '0;
      dma_dst_msb_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_ARB: begin
          if (win_found) begin
            rr_q  <= win_idx;
            idx_q <= win_idx;
            for (int c = 0; c < NCH; c++) begin
              if (win_idx == IW'(c)) begin
                dma_len_o     <= len_i[c*DATA_WIDTH +: DATA_WIDTH];
                dma_src_lsb_o <= src_lsb_i[c*DATA_WIDTH +: DATA_WIDTH];
                dma_src_msb_o <= src_msb_i[c*DATA_WIDTH +: DATA_WIDTH];
                dma_dst_lsb_o <= dst_lsb_i[c*DATA_WIDTH +: DATA_WIDTH];
                dma_dst_msb_o <= dst_msb_i[c*DATA_WIDTH +: DATA_WIDTH];
              end
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          to_q    <= 1'b0;
          ld_ok_q <= 1'b0;
          st_ok_q <= 1'b0;
        end
        // A real done wins over a timeout landing on the same cycle.
        S_WAIT: begin
          if (dma_valid_i[3]) begin
            ld_ok_q <= dma_valid_i[1];
            st_ok_q <= dma_valid_i[2];
          end else if (cnt_q == CNT_LAST) begin
            to_q    <= 1'b1;
            ld_ok_q <= 1'b0;
            st_ok_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so an async reset clears them immediately.
  always_comb begin
    gnt_o        = '0;
    cmp_valid_o  = '0;
    cmp_status_o = '0;
    if (state_q == S_ARB && win_found) gnt_o[win_idx] = 1'b1;
    if (state_q == S_REPORT) begin
      cmp_valid_o[idx_q] = 1'b1;
      cmp_status_o       = {to_q, ~st_ok_q, ~ld_ok_q};
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign dma_start_o = DATA_WIDTH'(state_q == S_ISSUE);
  assign dma_done_o  = DATA_WIDTH'(state_q == S_ACK);

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter with hand-computed expectations per scenario.
module tb_dma_channel_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NCH-1:0] req_i;
  logic [NCH*DW-1:0] len_i, src_lsb_i, src_msb_i, dst_lsb_i, dst_msb_i;
  logic [NCH-1:0] gnt_o, cmp_valid_o;
  logic [2:0]     cmp_status_o;
  logic           busy_o;
  logic [DW-1:0]  dma_start_o, dma_len_o, dma_src_lsb_o, dma_src_msb_o;
  logic [DW-1:0]  dma_dst_lsb_o, dma_dst_msb_o, dma_done_o, dma_valid_i;

  int total = 0;
  int bad   = 0;

  dma_channel_arbiter #(.NCH(NCH), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
    .len_i(len_i), .src_lsb_i(src_lsb_i), .src_msb_i(src_msb_i),
    .dst_lsb_i(dst_lsb_i), .dst_msb_i(dst_msb_i),
    .gnt_o(gnt_o), .cmp_valid_o(cmp_valid_o), .cmp_status_o(cmp_status_o),
    .busy_o(busy_o), .dma_start_o(dma_start_o), .dma_len_o(dma_len_o),
    .dma_src_lsb_o(dma_src_lsb_o), .dma_src_msb_o(dma_src_msb_o),
    .dma_dst_lsb_o(dma_dst_lsb_o), .dma_dst_msb_o(dma_dst_msb_o),
    .dma_done_o(dma_done_o), .dma_valid_i(dma_valid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic load_descriptors();
    for (int c = 0; c < NCH; c++) begin
      len_i[c*DW +: DW]     = 32'(c + 3);
      src_lsb_i[c*DW +: DW] = 32'h1000_0000 | 32'(c);
      src_msb_i[c*DW +: DW] = 32'h2000_0000 | 32'(c);
      dst_lsb_i[c*DW +: DW] = 32'h3000_0000 | 32'(c);
      dst_msb_i[c*DW +: DW] = 32'h4000_0000 | 32'(c);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0;
    dma_valid_i = '0;
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  // Waits (bounded) for a grant pulse; idx stays -1 if none shows up.
  task automatic wait_gnt(output int idx, output int waited);
    idx = -1;
    waited = 0;
    for (int t = 0; t < 40; t++) begin
      cyc();
      if (gnt_o != '0) begin
        for (int c = 0; c < NCH; c++) if (gnt_o[c]) idx = c;
        waited = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = 4'b1111;
    dma_valid_i = '1;
    load_descriptors();
    cyc();
    total++;
    if ({gnt_o, cmp_valid_o, cmp_status_o, busy_o} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %0h want 0", {gnt_o, cmp_valid_o, cmp_status_o, busy_o});
    end
    total++;
    if ({dma_start_o, dma_done_o, dma_len_o} !== 96'h0) begin
      bad++;
      $display("[TB] FAIL reset_dma: got %0h want 0", {dma_start_o, dma_done_o, dma_len_o});
    end
    total++;
    if ({dma_src_lsb_o, dma_src_msb_o, dma_dst_lsb_o, dma_dst_msb_o} !== 128'h0) begin
      bad++;
      $display("[TB] FAIL reset_addr: got %0h want 0",
               {dma_src_lsb_o, dma_src_msb_o, dma_dst_lsb_o, dma_dst_msb_o});
    end
    req_i = '0;
    dma_valid_i = '0;
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    int idx, waited;
    cyc();
    req_i = 4'b0001;
    wait_gnt(idx, waited);
    total++;
    if (idx !== 0 || waited !== 0) begin
      bad++;
      $display("[TB] FAIL single_gnt: got ch %0d after %0d want ch 0 after 0", idx, waited);
    end
    cyc();
    req_i = '0;
    len_i[0 +: DW] = 32'hDEAD_BEEF;
    total++;
    if (dma_start_o !== 32'd1 || dma_len_o !== 32'd3 || dma_src_lsb_o !== 32'h1000_0000
        || dma_dst_msb_o !== 32'h4000_0000) begin
      bad++;
      $display("[TB] FAIL single_issue: got start %0h len %0h src %0h dst %0h want 1 3 10000000 40000000",
               dma_start_o, dma_len_o, dma_src_lsb_o, dma_dst_msb_o);
    end
    cyc();
    dma_valid_i = 32'b1110;
    total++;
    if (dma_start_o !== 32'd0 || dma_len_o !== 32'd3) begin
      bad++;
      $display("[TB] FAIL single_wait: got start %0h len %0h want 0 3", dma_start_o, dma_len_o);
    end
    cyc();
    dma_valid_i = '0;
    total++;
    if (dma_done_o !== 32'd1) begin
      bad++;
      $display("[TB] FAIL single_ack: got done %0h want 1", dma_done_o);
    end
    cyc();
    total++;
    if (cmp_valid_o !== 4'b0001 || cmp_status_o !== 3'b000 || dma_done_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL single_report: got cmp %b st %b done %0h want 0001 000 0",
               cmp_valid_o, cmp_status_o, dma_done_o);
    end
    cyc();
    total++;
    if (busy_o !== 1'b0 || cmp_valid_o !== 4'b0000 || cmp_status_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL single_idle: got busy %b cmp %b st %b want 0 0000 000", busy_o, cmp_valid_o, cmp_status_o);
    end
    load_descriptors();
  endtask

  task automatic test_arb_abort();
    req_i = 4'b0001;
    cyc();
    req_i = '0;
    #1;
    total++;
    if (gnt_o !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL abort_gnt: got %b want 0000", gnt_o);
    end
    cyc();
    total++;
    if (busy_o !== 1'b0 || gnt_o !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL abort_idle: got busy %b gnt %b want 0 0000", busy_o, gnt_o);
    end
  endtask

  task automatic test_contention();
    int idx, waited;
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      wait_gnt(idx, waited);
      total++;
      if (idx !== k || waited !== 0) begin
        bad++;
        $display("[TB] FAIL contention_order%0d: got ch %0d after %0d want ch %0d after 0", k, idx, waited, k);
      end
      cyc();
      req_i[k] = 1'b0;
      total++;
      if (dma_start_o !== 32'd1 || dma_len_o !== 32'(k + 3)) begin
        bad++;
        $display("[TB] FAIL contention_issue%0d: got start %0h len %0h want 1 %0h", k, dma_start_o, dma_len_o, k + 3);
      end
      cyc();
      dma_valid_i = 32'b1110;
      cyc();
      dma_valid_i = '0;
      cyc();
      total++;
      if (cmp_valid_o !== 4'(1 << k) || cmp_status_o !== 3'b000) begin
        bad++;
        $display("[TB] FAIL contention_report%0d: got cmp %b st %b want %b 000", k, cmp_valid_o, cmp_status_o, 4'(1 << k));
      end
    end
  endtask

  task automatic test_pmp_denials();
    int idx, waited;
    logic [31:0] vw [3] = '{32'b1000, 32'b1010, 32'b1100};
    logic [2:0]  st [3] = '{3'b011, 3'b010, 3'b001};
    for (int v = 0; v < 3; v++) begin
      req_i = 4'b0010;
      wait_gnt(idx, waited);
      total++;
      if (idx !== 1) begin
        bad++;
        $display("[TB] FAIL pmp_gnt%0d: got ch %0d want 1", v, idx);
      end
      cyc();
      req_i = '0;
      cyc();
      dma_valid_i = vw[v];
      cyc();
      dma_valid_i = '0;
      cyc();
      total++;
      if (cmp_valid_o !== 4'b0010 || cmp_status_o !== st[v]) begin
        bad++;
        $display("[TB] FAIL pmp_status%0d: got cmp %b st %b want 0010 %b", v, cmp_valid_o, cmp_status_o, st[v]);
      end
    end
  endtask

  task automatic test_timeout();
    int idx, waited, n;
    cyc();
    req_i = 4'b1100;
    wait_gnt(idx, waited);
    total++;
    if (idx !== 2) begin
      bad++;
      $display("[TB] FAIL timeout_gnt: got ch %0d want 2", idx);
    end
    cyc();
    req_i = 4'b1000;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      cyc();
      if (dma_done_o[0]) break;
      n++;
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("[TB] FAIL timeout_cycles: got %0d wait cycles want 16", n);
    end
    cyc();
    total++;
    if (cmp_valid_o !== 4'b0100 || cmp_status_o !== 3'b111) begin
      bad++;
      $display("[TB] FAIL timeout_status: got cmp %b st %b want 0100 111", cmp_valid_o, cmp_status_o);
    end
    wait_gnt(idx, waited);
    total++;
    if (idx !== 3 || waited !== 0) begin
      bad++;
      $display("[TB] FAIL timeout_next: got ch %0d after %0d want ch 3 after 0", idx, waited);
    end
    cyc();
    req_i = '0;
    cyc();
    dma_valid_i = 32'b1110;
    cyc();
    dma_valid_i = '0;
    cyc();
    total++;
    if (cmp_valid_o !== 4'b1000 || cmp_status_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL timeout_after: got cmp %b st %b want 1000 000", cmp_valid_o, cmp_status_o);
    end
  endtask

  task automatic test_no_restart();
    int idx, waited, starts;
    cyc();
    req_i = 4'b0001;
    wait_gnt(idx, waited);
    cyc();
    req_i = '0;
    starts = int'(dma_start_o[0]);
    cyc();
    dma_valid_i = 32'b1110;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      starts += int'(dma_start_o[0]);
      total++;
      if ({dma_start_o[0], dma_done_o[0]} !== 2'b01) begin
        bad++;
        $display("[TB] FAIL no_restart_ack%0d: got start %b done %b want 0 1", i, dma_start_o[0], dma_done_o[0]);
      end
      if (i == 5) dma_valid_i = '0;
    end
    cyc();
    starts += int'(dma_start_o[0]);
    total++;
    if (cmp_valid_o !== 4'b0001 || dma_done_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL no_restart_report: got cmp %b done %0h want 0001 0", cmp_valid_o, dma_done_o);
    end
    total++;
    if (starts !== 1) begin
      bad++;
      $display("[TB] FAIL no_restart_starts: got %0d want 1", starts);
    end
  endtask

  task automatic test_reset_mid_wait();
    int idx, waited;
    cyc();
    req_i = 4'b0010;
    wait_gnt(idx, waited);
    cyc();
    req_i = '0;
    cyc();
    rst_ni = 1'b0;
    #1;
    total++;
    if ({gnt_o, cmp_valid_o, cmp_status_o, busy_o, dma_start_o[0], dma_done_o[0]} !== 14'h0
        || dma_len_o !== 32'd0 || dma_src_lsb_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got busy %b start %0h done %0h len %0h src %0h want all 0",
               busy_o, dma_start_o, dma_done_o, dma_len_o, dma_src_lsb_o);
    end
    cyc();
    rst_ni = 1'b1;
    req_i = 4'b0110;
    cyc();
    total++;
    if (gnt_o !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL midreset_pointer: got gnt %b want 0010", gnt_o);
    end
    do_reset();
    req_i = 4'b0100;
    cyc();
    total++;
    if (gnt_o !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL midreset_ch2: got gnt %b want 0100", gnt_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = '0;
    dma_valid_i = '0;
    len_i = '0;
    src_lsb_i = '0;
    src_msb_i = '0;
    dst_lsb_i = '0;
    dst_msb_i = '0;
    test_reset();
    test_single();
    test_arb_abort();
    test_contention();
    test_pmp_denials();
    test_timeout();
    test_no_restart();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
